// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one result bit per cycle, HI/LO outputs.
// Define MULDIV_DIV_EN to compile in the divider (ops 10/11); otherwise multiply-only.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_q;
`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_r;
  logic               r_div0;
  logic [WIDTH-1:0]   r_raw_a;
`endif

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_accept;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
`endif

  // Signs only matter for the signed ops (op[0]=1)
  assign w_sa    = op[0] & a[WIDTH-1];
  assign w_sb    = op[0] & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;

`ifdef MULDIV_DIV_EN
  assign w_accept = start && (r_state == S_IDLE);
`else
  assign w_accept = start && (r_state == S_IDLE) && !op[1];
`endif

  // Shift-add: upper half accumulates, multiplier bits shift out of the lower half
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring division: acc = {remainder, dividend/quotient}
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
  assign w_step      = r_is_div ? w_div_next : w_mul_next;
  assign w_quo       = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem       = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
  assign w_step      = w_mul_next;
`endif

  assign w_prod = r_neg_q ? -r_acc : r_acc;

  always_comb begin
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      if (r_div0) begin
        w_hi_fix = r_raw_a;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = w_rem;
        w_lo_fix = w_quo;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_raw_a  <= '0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_CALC;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_neg_q <= w_sa ^ w_sb;
`ifdef MULDIV_DIV_EN
            r_is_div <= op[1];
            r_neg_r  <= w_sa;
            r_div0   <= (b == '0);
            r_raw_a  <= a;
            r_opnd   <= op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
`else
            r_opnd   <= w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + ONE_CNT;
          if (r_cnt == LAST_CNT) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          hi      <= w_hi_fix;
          lo      <= w_lo_fix;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and completion edge,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           at;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk({e_mon.name, "_hi"}, hi, e_mon.hi);
        chk({e_mon.name, "_lo"}, lo, e_mon.lo);
        chk({e_mon.name, "_latency"}, edge_cnt, e_mon.at);
        $display("op %s: hi=%h lo=%h edge=%0d", e_mon.name, hi, lo, edge_cnt);
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge
  task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.hi  = eh;
    e.lo  = el;
    e.at  = edge_cnt + W + 2;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    chk({nm, "_busy_on_accept"}, busy, 1);
  endtask

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t dropped;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    // Exact handshake timing on the first op
    issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    repeat (W) @(negedge clk);
    chk("busy_last_calc", busy, 1);
    chk("done_last_calc", done, 0);
    @(negedge clk);
    chk("busy_after_fix", busy, 0);
    chk("done_after_fix", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    issue("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_idle(100);
    issue("mult_negneg", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h1E);
    wait_idle(100);

    // A start while busy must not disturb the in-flight op
    issue("multu_ign", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored", busy, 1);
    wait_idle(100);

    // Back-to-back: start in the done cycle
    issue("b2b_1", 2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
    wait_done(100);
    issue("b2b_2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    wait_idle(100);

    // Reset mid-operation aborts with no done pulse
    issue("rst_abort", 2'b00, 32'hDEAD_BEEF, 32'd3, 32'h2, 32'h9C09_3CCD);
    dropped = sb.pop_back();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 8) @(negedge clk);
    chk("abort_hi_hold", hi, 0);
    issue("after_rst", 2'b00, 32'hDEAD_BEEF, 32'd3, 32'h2, 32'h9C09_3CCD);
    wait_idle(100);

`ifdef MULDIV_DIV_EN
    issue("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_idle(100);
    issue("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle(100);
    issue("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    wait_idle(100);
    issue("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_idle(100);
    issue("divu_by0", 2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
    wait_idle(100);
    issue("div_by0", 2'b11, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    wait_idle(100);
`else
    // Divide ops are not accepted in the multiply-only build
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("divu_ignored_busy", busy, 0);
    start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("div_ignored_busy", busy, 0);
    repeat (W + 4) @(negedge clk);
    chk("div_ignored_hi", hi, 32'h2);
    chk("div_ignored_lo", lo, 32'h9C09_3CCD);
    issue("multu_7_6", 2'b00, 32'd7, 32'd6, 32'h0, 32'd42);
    wait_idle(100);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
